// File: rtl/cmd_parser.sv
// cmd_parser: framed host command decoder driving trace width/enable and FIFO flush.
// Define CMD_CHECKSUM_EN for 4-byte frames with a trailing CMD^ARG checksum byte.
module cmd_parser #(
  parameter int TIMEOUT_CYCLES = 48000,
  parameter int DEFAULT_WIDTH = 4
) (
  input  logic       clkOut,
  input  logic       rst,
  input  logic [7:0] rxByte,
  input  logic       rxTrig,
  input  logic       rxErr,
  output logic [2:0] width,
  output logic       traceEn,
  output logic       flushReq,
  output logic       cmdOk,
  output logic       cmdErr,
  output logic       busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
`ifdef CMD_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, CMD, ARG, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, CMD, ARG} state_t;
`endif
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_cmd;
  logic [2:0] r_width;
  logic r_trace, r_flush, r_ok, r_err, r_busy;
  logic w_byte, w_tmo, w_valid;
  logic [7:0] w_arg;
`ifdef CMD_CHECKSUM_EN
  logic [7:0] r_arg;
  assign w_arg = r_arg;
`else
  assign w_arg = rxByte;
`endif
  assign w_byte = rxTrig & ~rxErr;
  assign w_tmo = (r_state != IDLE) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    w_valid = (r_cmd == 8'h01 && (w_arg == 8'h01 || w_arg == 8'h02 || w_arg == 8'h04))
           || (r_cmd == 8'h02 && w_arg[7:1] == 7'd0)
           || (r_cmd == 8'h03);
`ifdef CMD_CHECKSUM_EN
    w_valid = w_valid && (rxByte == (r_cmd ^ r_arg));
`endif
  end
  always_ff @(posedge clkOut) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cmd   <= '0;
`ifdef CMD_CHECKSUM_EN
      r_arg   <= '0;
`endif
      r_width <= 3'(DEFAULT_WIDTH);
      r_trace <= 1'b0;
      r_flush <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      // Saturating inter-byte counter; held at zero while idle
      r_cnt <= (w_byte || r_state == IDLE) ? '0 : (r_cnt == CW'(TIMEOUT_CYCLES - 1)) ? r_cnt : r_cnt + 1'b1;
      if (r_state != IDLE && rxErr) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
      end else if (w_byte) begin
        if (r_state == IDLE) begin
          if (rxByte == 8'hA5) begin
            r_state <= CMD;
            r_busy  <= 1'b1;
          end
        end else if (r_state == CMD) begin
          r_cmd   <= rxByte;
          r_state <= ARG;
`ifdef CMD_CHECKSUM_EN
        end else if (r_state == ARG) begin
          r_arg   <= rxByte;
          r_state <= CHK;
`endif
        end else begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ok    <= w_valid;
          r_err   <= ~w_valid;
          if (w_valid && r_cmd == 8'h01) r_width <= w_arg[2:0];
          if (w_valid && r_cmd == 8'h02) r_trace <= w_arg[0];
          if (w_valid && r_cmd == 8'h03) r_flush <= 1'b1;
        end
      end else if (w_tmo) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
      end
    end
  end
  assign width    = r_width;
  assign traceEn  = r_trace;
  assign flushReq = r_flush;
  assign cmdOk    = r_ok;
  assign cmdErr   = r_err;
  assign busy     = r_busy;
endmodule
